// File: rtl/jellyvl_etherneco_synctimer_pkg.sv
// Shared packet layout for the etherneco sync-timer master and slave, so both
// ends agree on byte positions within the sync command and response payloads.
package jellyvl_etherneco_synctimer_pkg;

   localparam int CMD_POS      = 0;
   localparam int TIME_POS     = 1;
   localparam int TIME_BYTES   = 8;
   localparam int OFFSET_POS   = 9;
   localparam int OFFSET_BYTES = 4;

   localparam int CMD_VALID    = 0;
   localparam int CMD_OVERRIDE = 1;

   typedef logic [7:0][7:0] t_time;
   typedef logic [3:0][7:0] t_offset;
   typedef logic [15:0]     t_position;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_RES,
      ST_CALC
   } t_master_state;

   // Total payload length for n slave nodes: command, time, then n offsets.
   function automatic t_position packet_len(input logic [7:0] n);
      return t_position'(OFFSET_POS) + {6'd0, n, 2'b00};
   endfunction

endpackage

// File: rtl/jellyvl_etherneco_synctimer_offset_table.sv
// Per-node delay offset storage: byte-wide read port for packet building,
// word-wide write port for the offset calculation, cleared by reset.
module jellyvl_etherneco_synctimer_offset_table #(
   parameter int MAX_NODES    = 16,
   parameter int OFFSET_WIDTH = 32,
   parameter int IDX_W        = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [IDX_W-1:0]        rd_node,
   input  logic [1:0]              rd_byte,
   output logic [7:0]              rd_data,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_node,
   input  logic [OFFSET_WIDTH-1:0] wr_data
);

   logic [OFFSET_WIDTH-1:0] mem [MAX_NODES];
   logic [OFFSET_WIDTH-1:0] rd_word;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MAX_NODES; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_node] <= wr_data;
      end
   end

   assign rd_word = mem[rd_node] >> {rd_byte, 3'b000};
   assign rd_data = rd_word[7:0];

endmodule

// File: rtl/jellyvl_etherneco_synctimer_master.sv
// Etherneco sync-timer ring master: streams sync command packets and turns the
// returning per-slave elapsed times into one-way delay offsets.
//
//   state       | meaning
//   ST_IDLE     | waiting for trigger
//   ST_SEND     | streaming command, master time and offset table
//   ST_WAIT_RES | collecting response elapsed times, timeout running
//   ST_CALC     | one node per cycle: offset = (t_total - elapsed) / 2
module jellyvl_etherneco_synctimer_master
   import jellyvl_etherneco_synctimer_pkg::*;
#(
   parameter int TIMER_WIDTH    = 64,
   parameter int MAX_NODES      = 16,
   parameter int OFFSET_WIDTH   = 32,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [TIMER_WIDTH-1:0] current_time,
   input  logic [7:0]             node_count,
   input  logic                   trigger,
   input  logic [1:0]             trigger_cmd,
   output logic                   busy,
   output logic                   timeout,
   output logic                   m_cmd_first,
   output logic                   m_cmd_last,
   output logic [7:0]             m_cmd_data,
   output logic                   m_cmd_valid,
   input  logic                   m_cmd_ready,
   input  logic                   res_rx_start,
   input  logic                   res_rx_end,
   input  logic                   res_rx_error,
   input  logic [15:0]            s_res_pos,
   input  logic [7:0]             s_res_data,
   input  logic                   s_res_valid
);

   localparam int IDX_W = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1;
   localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   t_master_state           state, state_next;
   logic [1:0]              cmd_reg;
   logic [7:0]              n_nodes, n_clamped;
   t_position               pkt_len, pos, off_rel, res_rel;
   logic [2:0]              time_idx;
   logic [63:0]             time64;
   t_time                   t_send;
   logic [31:0]             t_start, t_total;
   logic                    start_seen, discard;
   logic [TO_W-1:0]         to_cnt;
   logic [IDX_W-1:0]        calc_idx, res_node;
   logic                    accept, res_hit, calc_done;
   logic [OFFSET_WIDTH-1:0] elapsed [MAX_NODES];
   logic [31:0]             calc_elapsed, calc_diff, calc_offset;
   logic [7:0]              tbl_rd_data;

   assign time64 = 64'(current_time);

   always_comb begin
      n_clamped = node_count;
      if (node_count == 8'd0) begin
         n_clamped = 8'd1;
      end else if (32'(node_count) > MAX_NODES) begin
         n_clamped = 8'(MAX_NODES);
      end
   end

   assign busy        = (state != ST_IDLE);
   assign m_cmd_valid = (state == ST_SEND);
   assign accept      = m_cmd_valid & m_cmd_ready;
   assign m_cmd_first = (pos == t_position'(CMD_POS));
   assign m_cmd_last  = (pos == pkt_len - 16'd1);

   assign off_rel  = pos - t_position'(OFFSET_POS);
   assign time_idx = 3'(pos - t_position'(TIME_POS));

   always_comb begin
      m_cmd_data = tbl_rd_data;
      if (pos == t_position'(CMD_POS)) begin
         m_cmd_data = {6'd0, cmd_reg};
      end else if (pos < t_position'(OFFSET_POS)) begin
         m_cmd_data = t_send[time_idx];
      end
   end

   assign calc_elapsed = 32'(elapsed[calc_idx]);
   assign calc_diff    = t_total - calc_elapsed;
   assign calc_offset  = (t_total >= calc_elapsed) ? (calc_diff >> 1) : 32'd0;
   assign calc_done    = (32'(calc_idx) + 32'd1 == 32'(n_nodes));

   jellyvl_etherneco_synctimer_offset_table #(
      .MAX_NODES    (MAX_NODES),
      .OFFSET_WIDTH (OFFSET_WIDTH),
      .IDX_W        (IDX_W)
   ) u_offset_table (
      .clk     (clk),
      .reset   (reset),
      .rd_node (IDX_W'(off_rel >> 2)),
      .rd_byte (off_rel[1:0]),
      .rd_data (tbl_rd_data),
      .wr_en   (state == ST_CALC),
      .wr_node (calc_idx),
      .wr_data (OFFSET_WIDTH'(calc_offset))
   );

   always_comb begin
      state_next = state;
      timeout    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (trigger) state_next = ST_SEND;
         end
         ST_SEND: begin
            if (accept && m_cmd_last) state_next = ST_WAIT_RES;
         end
         ST_WAIT_RES: begin
            // A start in the same cycle as end still counts as seen.
            if (res_rx_end) begin
               if (discard || res_rx_error || !(start_seen || res_rx_start)) begin
                  state_next = ST_IDLE;
               end else begin
                  state_next = ST_CALC;
               end
            end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
               timeout    = 1'b1;
               state_next = ST_IDLE;
            end
         end
         ST_CALC: begin
            if (calc_done) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         cmd_reg    <= '0;
         n_nodes    <= 8'd1;
         pkt_len    <= packet_len(8'd1);
         pos        <= '0;
         t_send     <= '0;
         t_start    <= '0;
         t_total    <= '0;
         start_seen <= 1'b0;
         discard    <= 1'b0;
         to_cnt     <= '0;
         calc_idx   <= '0;
      end else begin
         state <= state_next;
         case (state)
            ST_IDLE: begin
               if (trigger) begin
                  cmd_reg    <= trigger_cmd;
                  n_nodes    <= n_clamped;
                  pkt_len    <= packet_len(n_clamped);
                  pos        <= '0;
                  start_seen <= 1'b0;
                  discard    <= 1'b0;
               end
            end
            ST_SEND: begin
               to_cnt <= '0;
               if (accept) begin
                  pos <= pos + 16'd1;
                  if (m_cmd_first) begin
                     t_send  <= time64;
                     t_start <= time64[31:0];
                  end
               end
            end
            ST_WAIT_RES: begin
               to_cnt   <= to_cnt + TO_W'(1);
               calc_idx <= '0;
               if (res_rx_start) begin
                  t_total    <= time64[31:0] - t_start;
                  start_seen <= 1'b1;
               end
               if (res_rx_error) discard <= 1'b1;
            end
            ST_CALC: begin
               calc_idx <= calc_idx + IDX_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign res_rel  = s_res_pos - t_position'(OFFSET_POS);
   assign res_node = IDX_W'(res_rel >> 2);
   assign res_hit  = (state == ST_WAIT_RES) && s_res_valid
                     && (s_res_pos >= t_position'(OFFSET_POS)) && (s_res_pos < pkt_len);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < MAX_NODES; i++) begin
            elapsed[i] <= '0;
         end
      end else if (res_hit) begin
         elapsed[res_node][{res_rel[1:0], 3'b000} +: 8] <= s_res_data;
      end
   end

endmodule

// File: tb/tb_jellyvl_etherneco_synctimer_master.sv
// Bench for the sync-timer master: expected packet bytes are queued at trigger
// time from a per-node offset model and compared as the DUT emits them.
module tb_jellyvl_etherneco_synctimer_master;

   localparam int MAX_NODES = 16;
   localparam int TO_CYC    = 100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [63:0] current_time = 64'd0;
   logic [7:0]  node_count = 8'd1;
   logic        trigger = 1'b0;
   logic [1:0]  trigger_cmd = 2'd0;
   logic        busy, timeout;
   logic        m_cmd_first, m_cmd_last, m_cmd_valid;
   logic [7:0]  m_cmd_data;
   logic        m_cmd_ready = 1'b1;
   logic        res_rx_start = 1'b0, res_rx_end = 1'b0, res_rx_error = 1'b0;
   logic [15:0] s_res_pos = 16'd0;
   logic [7:0]  s_res_data = 8'd0;
   logic        s_res_valid = 1'b0;

   always #5 clk = ~clk;

   jellyvl_etherneco_synctimer_master #(
      .TIMER_WIDTH    (64),
      .MAX_NODES      (MAX_NODES),
      .OFFSET_WIDTH   (32),
      .TIMEOUT_CYCLES (TO_CYC)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .current_time (current_time),
      .node_count   (node_count),
      .trigger      (trigger),
      .trigger_cmd  (trigger_cmd),
      .busy         (busy),
      .timeout      (timeout),
      .m_cmd_first  (m_cmd_first),
      .m_cmd_last   (m_cmd_last),
      .m_cmd_data   (m_cmd_data),
      .m_cmd_valid  (m_cmd_valid),
      .m_cmd_ready  (m_cmd_ready),
      .res_rx_start (res_rx_start),
      .res_rx_end   (res_rx_end),
      .res_rx_error (res_rx_error),
      .s_res_pos    (s_res_pos),
      .s_res_data   (s_res_data),
      .s_res_valid  (s_res_valid)
   );

   int errors = 0;
   int checks = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // time base: free-running, with a one-cycle load for stimulus
   logic        time_load = 1'b0;
   logic [63:0] time_load_val = 64'd0;
   always @(posedge clk) current_time <= time_load ? time_load_val : current_time + 64'd1;

   // ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random
   int ready_mode = 0;
   int rcnt = 0;
   always @(posedge clk) begin
      rcnt <= rcnt + 1;
      case (ready_mode)
         0:       m_cmd_ready <= 1'b1;
         1:       m_cmd_ready <= ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
         default: m_cmd_ready <= 1'($urandom_range(0, 1));
      endcase
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] data;
      bit         first;
      bit         last;
      int         tidx;   // >= 0: byte of master time captured at byte0 accept
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] off_model [1:MAX_NODES];
   logic [31:0] resp_el   [1:MAX_NODES];

   // monitor / scoreboard
   exp_t        mon_e;
   logic [7:0]  mon_exp;
   logic [63:0] t_send_cap = 64'd0;
   logic [31:0] t_start_cap = 32'd0;
   int          pkt_done = 0;
   int          last_acc_cyc = 0;
   int          to_count = 0;
   int          to_cyc = 0;
   bit          to_pending = 0;
   logic        busy_after_to = 1'b1;
   bit          prev_stall = 0;
   logic [9:0]  prev_bus = '0;

   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
         prev_stall = 0;
      end else begin
         if (prev_stall)
            check("stall_hold", {m_cmd_valid, m_cmd_first, m_cmd_last, m_cmd_data}, {1'b1, prev_bus});
         prev_stall = m_cmd_valid && !m_cmd_ready;
         prev_bus   = {m_cmd_first, m_cmd_last, m_cmd_data};
         if (m_cmd_valid && m_cmd_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_byte: got 0x%0h, expected no byte", m_cmd_data);
            end else begin
               mon_e = exp_q.pop_front();
               if (mon_e.first) begin
                  t_send_cap  = current_time;
                  t_start_cap = current_time[31:0];
               end
               mon_exp = (mon_e.tidx >= 0) ? t_send_cap[8*mon_e.tidx +: 8] : mon_e.data;
               check("cmd_byte", {busy, m_cmd_first, m_cmd_last, m_cmd_data},
                     {1'b1, mon_e.first, mon_e.last, mon_exp});
               if (mon_e.last) begin
                  pkt_done++;
                  last_acc_cyc = cyc;
               end
            end
         end
         if (to_pending) begin
            busy_after_to = busy;
            to_pending    = 0;
         end
         if (timeout) begin
            to_count++;
            to_cyc     = cyc;
            to_pending = 1;
         end
      end
   end

   function automatic int clamp_n(input logic [7:0] nc);
      if (nc == 8'd0) return 1;
      if (int'(nc) > MAX_NODES) return MAX_NODES;
      return int'(nc);
   endfunction

   task automatic start_pkt(input logic [1:0] cmd, input logic [7:0] nc,
                            input logic [63:0] tload, output int n);
      exp_t e;
      n = clamp_n(nc);
      e.data = {6'd0, cmd}; e.first = 1; e.last = 0; e.tidx = -1;
      exp_q.push_back(e);
      for (int i = 0; i < 8; i++) begin
         e.data = 8'd0; e.first = 0; e.last = 0; e.tidx = i;
         exp_q.push_back(e);
      end
      for (int nd = 1; nd <= n; nd++) begin
         for (int k = 0; k < 4; k++) begin
            e.data = off_model[nd][8*k +: 8]; e.first = 0;
            e.last = (nd == n) && (k == 3); e.tidx = -1;
            exp_q.push_back(e);
         end
      end
      @(posedge clk); #1;
      trigger = 1'b1; trigger_cmd = cmd; node_count = nc;
      time_load = 1'b1; time_load_val = tload;
      @(posedge clk); #1;
      trigger = 1'b0; time_load = 1'b0;
      node_count = 8'($urandom); trigger_cmd = 2'($urandom);
   endtask

   task automatic wait_pkt_done(input int target);
      for (int i = 0; i < 4000 && pkt_done < target; i++) @(negedge clk);
      check("pkt_complete", 64'(pkt_done), 64'(target));
   endtask

   task automatic respond(input int n, input logic [31:0] start_lo,
                          input bit err, input bit no_start, input bit gaps);
      int          len;
      logic [31:0] total;
      int          rel;
      len = 9 + 4 * n;
      @(posedge clk); #1;
      time_load = 1'b1; time_load_val = {32'($urandom), start_lo};
      @(posedge clk); #1;
      time_load = 1'b0; res_rx_start = !no_start;
      for (int p = 0; p < len; p++) begin
         @(posedge clk); #1;
         res_rx_start = 1'b0;
         if (gaps && ($urandom_range(0, 7) == 0)) begin
            s_res_valid = 1'b0; res_rx_error = 1'b0;
            @(posedge clk); #1;
         end
         rel = p - 9;
         s_res_valid  = 1'b1;
         s_res_pos    = 16'(p);
         s_res_data   = (p >= 9) ? resp_el[rel / 4 + 1][8 * (rel % 4) +: 8] : 8'($urandom);
         res_rx_error = err && (p == len / 2);
      end
      @(posedge clk); #1;
      s_res_valid = 1'b0; res_rx_error = 1'b0; res_rx_end = 1'b1;
      @(posedge clk); #1;
      res_rx_end = 1'b0;
      total = start_lo - t_start_cap;
      if (!err && !no_start) begin
         for (int nd = 1; nd <= n; nd++)
            off_model[nd] = (total >= resp_el[nd]) ? (total - resp_el[nd]) / 2 : 32'd0;
      end
      for (int i = 0; i < 64 && busy; i++) @(negedge clk);
      check("idle_after_resp", 64'(busy), 64'd0);
   endtask

   initial begin
      int n;
      int pk;
      int to_before;
      logic [31:0] total;
      bit err, nost;

      for (int i = 1; i <= MAX_NODES; i++) begin
         off_model[i] = 32'd0;
         resp_el[i]   = 32'd0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_valid", 64'(m_cmd_valid), 64'd0);
      check("reset_timeout", 64'(timeout), 64'd0);
      reset = 1'b0;
      pk = 0;

      // basic packet, then response 1400-1000 = 400 -> offsets 50, 150
      start_pkt(2'b01, 8'd2, 64'd1000, n); pk++;
      wait_pkt_done(pk);
      resp_el[1] = 32'd300; resp_el[2] = 32'd100;
      respond(n, 32'd1400, 0, 0, 0);

      // stalled stream carries 0x32/0x96; errored response must not update
      ready_mode = 1;
      start_pkt(2'b10, 8'd2, 64'd5000, n); pk++;
      wait_pkt_done(pk);
      ready_mode = 0;
      resp_el[1] = 32'd7; resp_el[2] = 32'd9;
      respond(n, t_start_cap + 32'd900, 1, 0, 0);

      // offsets kept at 50/150; elapsed above total gives 0
      start_pkt(2'b11, 8'd2, 64'd20000, n); pk++;
      wait_pkt_done(pk);
      resp_el[1] = 32'd300; resp_el[2] = 32'd100;
      respond(n, t_start_cap + 32'd200, 0, 0, 0);

      // no response at all: single timeout pulse, offsets unchanged
      to_before = to_count;
      start_pkt(2'b00, 8'd2, 64'd30000, n); pk++;
      wait_pkt_done(pk);
      for (int i = 0; i < 300 && to_count == to_before; i++) @(negedge clk);
      repeat (150) @(negedge clk);
      check("timeout_pulses", 64'(to_count - to_before), 64'd1);
      check("timeout_delay", 64'(to_cyc - last_acc_cyc), 64'(TO_CYC));
      check("busy_after_timeout", 64'(busy_after_to), 64'd0);

      // 32-bit wrap of the round-trip time
      start_pkt(2'b01, 8'd3, 64'h0000_0001_FFFF_FF00, n); pk++;
      wait_pkt_done(pk);
      resp_el[1] = 32'h100; resp_el[2] = 32'h20; resp_el[3] = 32'h151;
      respond(n, 32'h0000_0050, 0, 0, 0);

      // randomized transactions, with a trigger during the busy period
      for (int t = 0; t < 8; t++) begin
         int r;
         logic [7:0] nc;
         ready_mode = $urandom_range(0, 2);
         r  = $urandom_range(0, 9);
         nc = (r == 0) ? 8'd0 : (r == 1) ? 8'($urandom_range(17, 255)) : 8'($urandom_range(1, 16));
         start_pkt(2'($urandom), nc, {$urandom, $urandom}, n); pk++;
         repeat (2) @(posedge clk);
         #1 trigger = 1'b1;
         @(posedge clk);
         #1 trigger = 1'b0;
         wait_pkt_done(pk);
         ready_mode = 0;
         total = $urandom_range(0, 100000);
         for (int nd = 1; nd <= n; nd++) resp_el[nd] = $urandom_range(0, int'(total) + 50);
         err  = ($urandom_range(0, 4) == 0);
         nost = !err && ($urandom_range(0, 7) == 0);
         respond(n, t_start_cap + total, err, nost, n <= 8);
      end

      // reset mid-packet drops the stream and clears the table
      ready_mode = 0;
      start_pkt(2'b01, 8'd4, 64'd777, n);
      repeat (4) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1;
      check("reset_mid_valid", 64'(m_cmd_valid), 64'd0);
      check("reset_mid_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      for (int i = 1; i <= MAX_NODES; i++) off_model[i] = 32'd0;
      @(negedge clk);
      pk = pkt_done;

      start_pkt(2'b10, 8'd16, 64'd123456, n); pk++;
      wait_pkt_done(pk);
      for (int nd = 1; nd <= n; nd++) resp_el[nd] = $urandom_range(0, 3000);
      respond(n, t_start_cap + 32'd2000, 0, 0, 0);
      start_pkt(2'b01, 8'd16, 64'd999999, n); pk++;
      wait_pkt_done(pk);
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: got no completion, expected finish before time limit");
      $fatal(1, "watchdog");
   end

endmodule
